pass_checker: RTL and testbench

//  Password-side responder to the ID lookup stage. It accepts the ID stage's handshake
//  (idChecked plus pass_Adrs) and fetches the stored password from the password ROM.
//  It then compares the password against the 4-digit keypad entry and reports grant,

---
 rtl/pass_checker_if.sv | 28 ++
 rtl/pass_checker.sv | 148 ++++++++++++++
 tb/tb_pass_checker.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pass_checker_if.sv
// Signal bundle around pass_checker: ID-stage handshake, keypad entry,
// password ROM port and the status outputs.
interface pass_checker_if;
  logic        idChecked;
  logic [2:0]  pass_Adrs;
  logic        passIn;
  logic [3:0]  Out1;
  logic [3:0]  Out2;
  logic [3:0]  Out3;
  logic [3:0]  Out4;
  logic [15:0] ROM_PASS;
  logic [2:0]  rom_Adrs;
  logic        passOut;
  logic        granted;
  logic        denied;
  logic        lockout;
  logic [1:0]  tries;

  modport slave (
    input  idChecked, pass_Adrs, passIn, Out1, Out2, Out3, Out4, ROM_PASS,
    output rom_Adrs, passOut, granted, denied, lockout, tries
  );

  modport master (
    output idChecked, pass_Adrs, passIn, Out1, Out2, Out3, Out4, ROM_PASS,
    input  rom_Adrs, passOut, granted, denied, lockout, tries
  );
endinterface

// File: rtl/pass_checker.sv
// Password stage: fetches the stored password for the matched ID, checks keypad
// entries against it and closes the 4-phase handshake with the ID stage.
module pass_checker #(
  parameter int ROM_LAT     = 2,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  pass_checker_if.slave bus
);
  localparam int CNT_MAX = (LOCK_CYCLES > ROM_LAT) ? LOCK_CYCLES : ROM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_FETCH, S_ENTRY, S_CHECK, S_LOCK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      exp_q, exp_d;
  logic [15:0]      ent_q, ent_d;
  logic [2:0]       adrs_q, adrs_d;
  logic [1:0]       tries_q, tries_d;
  logic             granted_q, granted_d;
  logic             denied_q, denied_d;
  logic             lockout_q, lockout_d;
  logic             passout_q, passout_d;

  logic abort, fetch_end, lock_end, match, last_try;

  // Dropping idChecked mid-session returns to IDLE regardless of other inputs.
  assign abort     = !bus.idChecked &&
                     (state_q inside {S_LATCH, S_FETCH, S_ENTRY, S_CHECK, S_LOCK});
  assign fetch_end = (cnt_q == CNT_W'(ROM_LAT - 1));
  assign lock_end  = (cnt_q == CNT_W'(LOCK_CYCLES - 1));
  assign match     = (ent_q == exp_q);
  assign last_try  = (({1'b0, tries_q} + 3'd1) == 3'(MAX_TRIES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      ent_q     <= '0;
      adrs_q    <= '0;
      tries_q   <= '0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      lockout_q <= 1'b0;
      passout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      ent_q     <= ent_d;
      adrs_q    <= adrs_d;
      tries_q   <= tries_d;
      granted_q <= granted_d;
      denied_q  <= denied_d;
      lockout_q <= lockout_d;
      passout_q <= passout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.idChecked) state_d = S_LATCH;
        S_LATCH: state_d = S_FETCH;
        S_FETCH: if (fetch_end) state_d = S_ENTRY;
        S_ENTRY: if (bus.passIn) state_d = S_CHECK;
        S_CHECK: begin
          if (match)         state_d = S_DONE;
          else if (last_try) state_d = S_LOCK;
          else               state_d = S_ENTRY;
        end
        S_LOCK:  if (lock_end) state_d = S_DONE;
        S_DONE:  if (!bus.idChecked) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    ent_d     = ent_q;
    adrs_d    = adrs_q;
    tries_d   = tries_q;
    granted_d = granted_q;
    denied_d  = 1'b0;
    lockout_d = lockout_q;
    passout_d = passout_q;
    if (abort) begin
      lockout_d = 1'b0;
      passout_d = 1'b0;
    end else begin
      case (state_q)
        S_LATCH: begin
          adrs_d    = bus.pass_Adrs;
          tries_d   = '0;
          granted_d = 1'b0;
          cnt_d     = '0;
        end
        S_FETCH: begin
          if (fetch_end) exp_d = bus.ROM_PASS;
          else           cnt_d = cnt_q + CNT_W'(1);
        end
        S_ENTRY: if (bus.passIn) ent_d = {bus.Out1, bus.Out2, bus.Out3, bus.Out4};
        S_CHECK: begin
          if (match) begin
            granted_d = 1'b1;
            passout_d = 1'b1;
          end else begin
            tries_d = tries_q + 2'd1;
            if (last_try) begin
              lockout_d = 1'b1;
              cnt_d     = '0;
            end else begin
              denied_d  = 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (lock_end) begin
            lockout_d = 1'b0;
            passout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  if (!bus.idChecked) passout_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.rom_Adrs = adrs_q;
  assign bus.passOut  = passout_q;
  assign bus.granted  = granted_q;
  assign bus.denied   = denied_q;
  assign bus.lockout  = lockout_q;
  assign bus.tries    = tries_q;
endmodule

// File: tb/tb_pass_checker.sv
// Bench for pass_checker: directed scenarios with literal expectations, then
// randomized sessions checked each cycle against a session-timeline model.
module tb_pass_checker;
  localparam int ROM_LAT     = 2;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pass_checker_if bus ();

  pass_checker #(
    .ROM_LAT    (ROM_LAT),
    .MAX_TRIES  (MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Synchronous password ROM; data is stable well before the end of FETCH.
  logic [15:0] rom [8];
  always @(posedge clk) bus.ROM_PASS <= rom[bus.rom_Adrs];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a session is a timeline of edge numbers (latch, keypad open,
  // pending verdict, lock release) rather than a state machine.
  int          edge_n = 0;
  bit          sess = 0, fin = 0;
  int          latch_at = -1, open_at = -1, judge_at = -1, lock_end = -1;
  logic [15:0] m_ent = '0;
  logic [2:0]  e_adrs = '0;
  logic        e_pass = 0, e_grant = 0, e_den = 0, e_lock = 0;
  logic [1:0]  e_tries = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sess = 0; fin = 0; judge_at = -1; lock_end = -1; m_ent = '0;
      e_adrs = '0; e_pass = 0; e_grant = 0; e_den = 0; e_lock = 0; e_tries = '0;
    end else begin
      edge_n++;
      e_den = 1'b0;
      if (!sess && !fin) begin
        if (bus.idChecked) begin
          sess = 1; latch_at = edge_n + 1; open_at = edge_n + 2 + ROM_LAT;
          judge_at = -1; lock_end = -1;
        end
      end else if (fin) begin
        if (!bus.idChecked) begin fin = 0; e_pass = 0; end
      end else if (!bus.idChecked) begin
        sess = 0; e_lock = 0; e_pass = 0;
      end else if (edge_n == latch_at) begin
        e_adrs = bus.pass_Adrs; e_tries = '0; e_grant = 0;
      end else if (edge_n == judge_at) begin
        judge_at = -1;
        if (m_ent == rom[e_adrs]) begin
          e_grant = 1; e_pass = 1; sess = 0; fin = 1;
        end else begin
          e_tries++;
          if (int'(e_tries) == MAX_TRIES) begin
            e_lock = 1; lock_end = edge_n + LOCK_CYCLES;
          end else begin
            e_den = 1;
          end
        end
      end else if (edge_n == lock_end) begin
        e_lock = 0; e_pass = 1; sess = 0; fin = 1;
      end else if (edge_n >= open_at && judge_at < 0 && lock_end < 0 && bus.passIn) begin
        m_ent = {bus.Out1, bus.Out2, bus.Out3, bus.Out4};
        judge_at = edge_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rom_Adrs", 16'(bus.rom_Adrs), 16'(e_adrs));
      check("passOut",  16'(bus.passOut),  16'(e_pass));
      check("granted",  16'(bus.granted),  16'(e_grant));
      check("denied",   16'(bus.denied),   16'(e_den));
      check("lockout",  16'(bus.lockout),  16'(e_lock));
      check("tries",    16'(bus.tries),    16'(e_tries));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [15:0] v);
    bus.passIn = 1'b1;
    {bus.Out1, bus.Out2, bus.Out3, bus.Out4} = v;
    tick(1);
    bus.passIn = 1'b0;
  endtask

  // Raises idChecked and returns once the block is waiting for keypad entry.
  task automatic open_session(input logic [2:0] a);
    bus.pass_Adrs   = a;
    bus.idChecked   = 1'b1;
    tick(2 + ROM_LAT);
  endtask

  task automatic close_session();
    bus.idChecked = 1'b0;
    tick(1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {4'd0, bus.rom_Adrs, bus.passOut, bus.granted, bus.denied,
                 bus.lockout, bus.tries, 3'd0}, 16'd0);
  endtask

  logic [15:0] pwd;
  int          sh;

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 16'($urandom);
    rom[3] = 16'h1234;
    if (rom[5] == 16'h1234) rom[5] = 16'hBEEF;
    bus.idChecked = 1'b0; bus.pass_Adrs = '0; bus.passIn = 1'b0;
    bus.Out1 = '0; bus.Out2 = '0; bus.Out3 = '0; bus.Out4 = '0;

    @(negedge clk);
    check_all_zero("reset_state");
    #2 rst = 1'b1;
    tick(1);

    // Grant on the first try, then the 4-phase close.
    open_session(3);
    check("t2_rom_Adrs", 16'(bus.rom_Adrs), 16'd3);
    key(16'h1234);
    check("t2_granted_not_yet", 16'(bus.granted), 16'd0);
    tick(1);
    check("t2_granted", 16'(bus.granted), 16'd1);
    check("t2_passOut", 16'(bus.passOut), 16'd1);
    close_session();
    check("t2_passOut_fall", 16'(bus.passOut), 16'd0);
    check("t2_granted_held", 16'(bus.granted), 16'd1);

    // One wrong entry, then the right one.
    open_session(3);
    key(16'h1235);
    tick(1);
    check("t3_denied", 16'(bus.denied), 16'd1);
    check("t3_tries1", 16'(bus.tries), 16'd1);
    key(16'h1234);
    check("t3_denied_pulse", 16'(bus.denied), 16'd0);
    tick(1);
    check("t3_granted", 16'(bus.granted), 16'd1);
    check("t3_tries_kept", 16'(bus.tries), 16'd1);
    close_session();

    // Three wrong entries lead to lockout.
    open_session(5);
    for (int k = 0; k < 2; k++) begin
      key(rom[5] ^ 16'h0001);
      tick(1);
      check("t4_denied", 16'(bus.denied), 16'd1);
      check("t4_tries", 16'(bus.tries), 16'(k + 1));
    end
    key(rom[5] ^ 16'h0001);
    tick(1);
    check("t4_lockout", 16'(bus.lockout), 16'd1);
    check("t4_tries3", 16'(bus.tries), 16'd3);
    check("t4_no_denied", 16'(bus.denied), 16'd0);
    tick(LOCK_CYCLES - 1);
    check("t4_lock_held", 16'(bus.lockout), 16'd1);
    check("t4_passOut_low", 16'(bus.passOut), 16'd0);
    tick(1);
    check("t4_lock_release", 16'(bus.lockout), 16'd0);
    check("t4_passOut", 16'(bus.passOut), 16'd1);
    close_session();

    // Keypad strobe during FETCH is ignored.
    bus.pass_Adrs = 3; bus.idChecked = 1'b1;
    tick(2);
    key(16'h1234);
    tick(6);
    check("t5_no_grant", 16'(bus.granted), 16'd0);
    check("t5_no_passOut", 16'(bus.passOut), 16'd0);
    key(16'h1234);
    tick(1);
    check("t5_grant_after", 16'(bus.granted), 16'd1);
    close_session();

    // Abort in ENTRY keeps tries; a new session restarts them.
    open_session(3);
    key(16'h0000);
    tick(1);
    bus.idChecked = 1'b0;
    tick(1);
    check("t6_passOut", 16'(bus.passOut), 16'd0);
    check("t6_tries_kept", 16'(bus.tries), 16'd1);
    open_session(3);
    check("t6_tries_restart", 16'(bus.tries), 16'd0);
    key(16'h1234);
    tick(1);
    check("t6_granted", 16'(bus.granted), 16'd1);
    close_session();

    // Asynchronous reset in the middle of FETCH.
    bus.pass_Adrs = 3; bus.idChecked = 1'b1;
    tick(2);
    check("t1_in_fetch_adrs", 16'(bus.rom_Adrs), 16'd3);
    #2 rst = 1'b0;
    #1 check_all_zero("t1_async_reset");
    bus.idChecked = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    tick(1);

    // Randomized sessions with aborts and mixed right/wrong entries.
    for (int c = 0; c < 4000; c++) begin
      if (!bus.idChecked) begin
        if (!bus.passOut && $urandom_range(0, 3) == 0) begin
          bus.pass_Adrs = 3'($urandom);
          bus.idChecked = 1'b1;
        end
      end else if (bus.passOut) begin
        if ($urandom_range(0, 2) == 0) bus.idChecked = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        bus.idChecked = 1'b0;
      end
      sh  = int'($urandom_range(0, 15));
      pwd = rom[bus.pass_Adrs];
      if ($urandom_range(0, 2) != 0) pwd = pwd ^ (16'(1) << sh);
      bus.passIn = ($urandom_range(0, 3) == 0);
      {bus.Out1, bus.Out2, bus.Out3, bus.Out4} = pwd;
      tick(1);
    end
    bus.passIn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
